burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
Two-master arbiter that shares a single BurstRAM port between two requesters, for example an instruction cache and a data cache.
Each master sees a BurstRAM-like interface with a valid/busy handshake. The arbiter forwards the winning command and holds ownership until the whole burst completes: BURST_COUNT read beats returned, or BURST_COUNT write words passed. It sits between the Cache instances and BurstRAM.

Parameters:
DEPTH_BITWIDTH, 10, width of the 8-byte word address on all ports
BURST_COUNT, 4, 64-bit words per burst (read and write); must be at least 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_cmd  in  1  0: read, 1: write
m0_cmd_en  in  1  command valid; held with cmd/addr/wr_data until accepted
m0_addr  in  DEPTH_BITWIDTH  burst word address
m0_wr_data  in  64  write word (first word with cmd_en, then one per cycle)
m0_data_mask  in  8  forwarded unchanged
m0_rd_data  out  64  read data (shared copy of br_rd_data)
m0_rd_data_valid  out  1  read beat valid for master 0
m0_busy  out  1  1: command not accepted this cycle
m1_*  same set as m0_*, for master 1
br_cmd  out  1  to BurstRAM cmd
br_cmd_en  out  1  to BurstRAM cmd_en
br_addr  out  DEPTH_BITWIDTH  to BurstRAM addr
br_wr_data  out  64  to BurstRAM wr_data
br_data_mask  out  8  to BurstRAM data_mask
br_rd_data  in  64  from BurstRAM
br_rd_data_valid  in  1  from BurstRAM
br_busy  in  1  from BurstRAM; 1 while calibrating or unable to accept

Behaviour:
- Registered state: state {IDLE, READ, WRITE}, owner (1 bit), beat counter (clog2(BURST_COUNT) bits), last_grant (1 bit).
- Reset values: state=IDLE, counter=0, last_grant=1, so m0 wins the first tie. During rst: m0_busy=m1_busy=1, br_cmd_en=0, mN_rd_data_valid=0.
- Handshake: a transfer occurs on the cycle where mN_cmd_en=1 and mN_busy=0. A master keeps cmd_en, cmd, addr and wr_data stable until that cycle.
- mN_busy is combinational: rst, OR br_busy, OR state != IDLE, OR (other master's cmd_en=1 AND the other master wins the tie). mN_busy does not depend on mN_cmd_en, so there is no loop.
- Tie (both cmd_en=1 in IDLE): the winner is the master not equal to last_grant (round-robin).
- IDLE, acceptance cycle:
  - br_cmd_en=1 in the same cycle (zero latency).
  - br_cmd/br_addr/br_wr_data/br_data_mask are muxed from the winner.
  - Registered updates: owner<=winner, last_grant<=winner, counter<=0.
  - Next state is READ (cmd=0) or WRITE (cmd=1).
- IDLE, no acceptance: br_cmd_en=0; br_* data outputs follow m0 (don't-care).
- WRITE: lasts exactly BURST_COUNT-1 cycles.
  - br_wr_data/br_data_mask come from the owner; the owner presents word k on cycle k after acceptance.
  - counter increments each cycle; at counter==BURST_COUNT-2, state<=IDLE.
  - br_cmd_en=0 throughout.
- READ: br_rd_data is fanned out to both mN_rd_data.
  - mN_rd_data_valid = br_rd_data_valid AND state==READ AND owner==N. The non-owner never sees valid.
  - counter increments on each valid beat; on the valid beat with counter==BURST_COUNT-1, state<=IDLE.
  - The next command can be accepted in the cycle after the final beat.
- br_rd_data_valid outside READ is ignored and not routed.
- br_busy=1 while IDLE blocks both masters; it has no effect inside READ/WRITE.
- rst mid-burst: returns to IDLE and clears the counter in the next cycle. The partial burst is dropped; BurstRAM is reset by the same signal.
- Read latency added by the arbiter: 0 cycles (pure mux/gating). A master's worst-case wait is one full burst of the other master.

Optional Feature:
BURST_RAM_ARBITER_FIXED_PRIORITY_EN:
- When defined: m0 always wins a tie, and last_grant is not used for the decision (still updated).
- When undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
1. Bench: BurstRAM with BURST_COUNT=4, CYCLES_BEFORE_DATA_VALID=6.
   m0 read at addr 0x010 alone -> br_cmd_en is a single cycle with br_addr=0x010; m0_rd_data_valid high for exactly 4 beats; m1_rd_data_valid stays 0; m0_busy=0 again the cycle after the 4th beat.
2. m1 write at addr 0x020, words 0x11..,0x22..,0x33..,0x44.. on consecutive cycles.
   -> br_wr_data carries the 4 words on 4 consecutive cycles; m0 busy for those cycles.
   -> A subsequent m1 read of 0x020 returns the same 4 words.
3. m0 and m1 assert cmd_en in the same cycle, repeated 4 times back to back.
   -> Grants alternate m0, m1, m0, m1; each master gets 2 bursts.
   -> With FIXED_PRIORITY_EN defined: m0 is granted on every tie.
4. Both masters request during calibration (br_busy=1).
   -> Both busy, br_cmd_en=0.
   -> The first grant goes to m0 in the first cycle with br_busy=0.
5. Assert rst during the 2nd beat of an m0 read.
   -> Next cycle: state IDLE, both busy=1 while rst held, no further mN_rd_data_valid.
   -> After rst release and calibration, an m1 read of 0x000 completes normally with 4 beats.
6. Spurious br_rd_data_valid pulse in IDLE -> neither m0_rd_data_valid nor m1_rd_data_valid asserts.

Source files
------------

// File: rtl/burst_ram_arbiter_if.sv
// BurstRAM-style command/data port shared by the cache masters and BurstRAM.
//   cmd           0: read, 1: write
//   cmd_en        command valid; held with cmd/addr/wr_data until accepted
//   addr          burst word address (8-byte words)
//   wr_data       write word (first with cmd_en, then one per cycle)
//   data_mask     byte mask, forwarded unchanged
//   rd_data       read data beat
//   rd_data_valid read beat valid
//   busy          1: command not accepted this cycle
// Modports: master = side issuing commands, slave = side accepting them.
interface burst_ram_arbiter_if #(
    parameter int DEPTH_BITWIDTH = 10
);
    logic                      cmd;
    logic                      cmd_en;
    logic [DEPTH_BITWIDTH-1:0] addr;
    logic [63:0]               wr_data;
    logic [7:0]                data_mask;
    logic [63:0]               rd_data;
    logic                      rd_data_valid;
    logic                      busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-master arbiter sharing one BurstRAM port (e.g. I-cache and D-cache).
// The winning command is forwarded with zero latency and the arbiter keeps
// ownership until the whole burst is done: BURST_COUNT read beats returned
// or BURST_COUNT write words passed.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   m0   master 0 port (slave modport): cmd/cmd_en/addr/wr_data/data_mask in,
//        rd_data/rd_data_valid/busy out
//   m1   master 1 port, same as m0
//   br   BurstRAM port (master modport)
//
// Parameters:
//   DEPTH_BITWIDTH  width of the 8-byte word address
//   BURST_COUNT     64-bit words per burst, at least 2
//
// Build option:
//   BURST_RAM_ARBITER_FIXED_PRIORITY_EN  when defined m0 always wins a tie;
//   otherwise ties are resolved round-robin against last_grant.
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 10,
    parameter int BURST_COUNT    = 4
) (
    input logic                clk,
    input logic                rst,
    burst_ram_arbiter_if.slave  m0,
    burst_ram_arbiter_if.slave  m1,
    burst_ram_arbiter_if.master br
);

    localparam int CNT_W = $clog2(BURST_COUNT);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(BURST_COUNT - 2);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t           state, state_n;
    logic             owner, owner_n;
    logic             last_grant, last_grant_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic tie_winner;
    logic winner;
    logic accept;
    logic sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
        end
    end

    always_comb begin
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        tie_winner = 1'b0;
`else
        tie_winner = ~last_grant;
`endif
        // Without a tie the sole requester wins; with no requester the value
        // is irrelevant because accept stays low.
        winner = (m0.cmd_en && m1.cmd_en) ? tie_winner : m1.cmd_en;
        accept = !rst && (state == IDLE) && !br.busy && (m0.cmd_en || m1.cmd_en);

        // busy never looks at the master's own cmd_en, so there is no
        // combinational loop through a master that waits for busy==0.
        m0.busy = rst || br.busy || (state != IDLE) || (m1.cmd_en && tie_winner);
        m1.busy = rst || br.busy || (state != IDLE) || (m0.cmd_en && !tie_winner);

        // Data path source: the winner on the acceptance cycle, the owner
        // during a burst, m0 otherwise.
        if (state == IDLE) begin
            sel = accept && winner;
        end else begin
            sel = owner;
        end

        br.cmd_en    = accept;
        br.cmd       = sel ? m1.cmd       : m0.cmd;
        br.addr      = sel ? m1.addr      : m0.addr;
        br.wr_data   = sel ? m1.wr_data   : m0.wr_data;
        br.data_mask = sel ? m1.data_mask : m0.data_mask;

        m0.rd_data       = br.rd_data;
        m1.rd_data       = br.rd_data;
        m0.rd_data_valid = !rst && br.rd_data_valid && (state == READ) && !owner;
        m1.rd_data_valid = !rst && br.rd_data_valid && (state == READ) && owner;
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    owner_n      = winner;
                    last_grant_n = winner;
                    cnt_n        = '0;
                    state_n      = br.cmd ? WRITE : READ;
                end
            end
            WRITE: begin
                // The first word went out with cmd_en, so the remaining
                // BURST_COUNT-1 words take exactly BURST_COUNT-1 cycles.
                cnt_n = cnt + 1'b1;
                if (cnt == WR_LAST) begin
                    state_n = IDLE;
                end
            end
            READ: begin
                if (br.rd_data_valid) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == RD_LAST) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: behavioural BurstRAM memory,
// reference memory image, per-master expected-read-data queues checked by
// a negedge monitor, plus directed grant-order and reset checks.
module tb_burst_ram_arbiter;
    localparam int DW  = 10;
    localparam int B   = 4;
    localparam int LAT = 6;
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(DW)) m0_if ();
    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(DW)) m1_if ();
    burst_ram_arbiter_if #(.DEPTH_BITWIDTH(DW)) br_if ();

    burst_ram_arbiter #(.DEPTH_BITWIDTH(DW), .BURST_COUNT(B)) dut (
        .clk(clk),
        .rst(rst),
        .m0 (m0_if),
        .m1 (m1_if),
        .br (br_if)
    );

    // master-side drive and observation arrays
    logic          m_en   [2];
    logic          m_cmd  [2];
    logic [DW-1:0] m_addr [2];
    logic [63:0]   m_wd   [2];
    logic [7:0]    m_mask [2];
    logic          m_busy [2];
    logic          m_valid[2];
    logic [63:0]   m_rd   [2];

    assign m0_if.cmd_en = m_en[0];   assign m1_if.cmd_en = m_en[1];
    assign m0_if.cmd = m_cmd[0];     assign m1_if.cmd = m_cmd[1];
    assign m0_if.addr = m_addr[0];   assign m1_if.addr = m_addr[1];
    assign m0_if.wr_data = m_wd[0];  assign m1_if.wr_data = m_wd[1];
    assign m0_if.data_mask = m_mask[0]; assign m1_if.data_mask = m_mask[1];
    assign m_busy[0] = m0_if.busy;   assign m_busy[1] = m1_if.busy;
    assign m_valid[0] = m0_if.rd_data_valid; assign m_valid[1] = m1_if.rd_data_valid;
    assign m_rd[0] = m0_if.rd_data;  assign m_rd[1] = m1_if.rd_data;

    logic        br_busy_drv;
    logic        ram_valid = 1'b0;
    logic [63:0] ram_data  = '0;
    assign br_if.busy          = br_busy_drv;
    assign br_if.rd_data_valid = ram_valid;
    assign br_if.rd_data       = ram_data;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference memory image and scoreboard
    logic [63:0] ref_mem[1024];
    logic [63:0] expq0[$];
    logic [63:0] expq1[$];
    int          beats[2];
    int          grant_q[$];
    int          ref_last;

    function automatic int tie_pick(input int last);
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
        return 0;
`else
        return 1 - last;
`endif
    endfunction

    // behavioural BurstRAM
    typedef struct {
        int          due;
        logic [63:0] data;
    } beat_t;
    logic [63:0]   ram[1024];
    beat_t         pend[$];
    int            cyc = 0;
    int            wr_idx = 0;
    logic [DW-1:0] wr_base;
    logic          spurious = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            wr_idx = 0;
        end else begin
            if (wr_idx != 0) begin
                ram[wr_base + DW'(wr_idx)] = br_if.wr_data;
                wr_idx = (wr_idx == B - 1) ? 0 : wr_idx + 1;
            end
            if (br_if.cmd_en) begin
                if (br_if.cmd) begin
                    ram[br_if.addr] = br_if.wr_data;
                    wr_base = br_if.addr;
                    wr_idx  = 1;
                end else begin
                    for (int k = 0; k < B; k++)
                        pend.push_back('{due: cyc + LAT + k, data: ram[br_if.addr + DW'(k)]});
                end
            end
        end
        #1;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ram_data  = pend[0].data;
            ram_valid = 1'b1;
            void'(pend.pop_front());
        end else if (spurious) begin
            ram_data  = {$urandom, $urandom};
            ram_valid = 1'b1;
            spurious  = 1'b0;
        end else begin
            ram_valid = 1'b0;
        end
    end

    // monitor: every read beat presented to a master must match its queue head
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        for (int n = 0; n < 2; n++) begin
            if (m_valid[n]) begin
                beats[n]++;
                if ((n == 0 ? expq0.size() : expq1.size()) == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat_m%0d: got beat %h expected no beat", n, m_rd[n]);
                end else begin
                    e = (n == 0) ? expq0.pop_front() : expq1.pop_front();
                    check($sformatf("rd_data_m%0d", n), m_rd[n], e);
                end
            end
        end
    end

    // Issue one burst from master n; called and returning at posedge+1.
    task automatic issue(input int n, input logic cmd, input logic [DW-1:0] addr,
                         input logic [255:0] words);
        logic [7:0] mask;
        bit         got = 0;
        mask = 8'($urandom);
        for (int k = 0; k < B; k++) begin
            if (cmd) ref_mem[addr + DW'(k)] = words[k*64 +: 64];
            else if (n == 0) expq0.push_back(ref_mem[addr + DW'(k)]);
            else expq1.push_back(ref_mem[addr + DW'(k)]);
        end
        m_cmd[n]  = cmd;
        m_addr[n] = addr;
        m_wd[n]   = words[63:0];
        m_mask[n] = mask;
        m_en[n]   = 1'b1;
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (!m_busy[n]) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout_m%0d: got no grant expected grant within %0d cycles", n, TMO);
            m_en[n] = 1'b0;
            return;
        end
        grant_q.push_back(n);
        check("br_cmd_en_accept", br_if.cmd_en, 1);
        check("br_addr", br_if.addr, addr);
        check("br_cmd", br_if.cmd, cmd);
        check("br_data_mask", br_if.data_mask, mask);
        if (cmd) check("br_wr_data_w0", br_if.wr_data, words[63:0]);
        @(posedge clk);
        #1;
        m_en[n] = 1'b0;
        if (cmd) begin
            for (int k = 1; k < B; k++) begin
                m_wd[n] = words[k*64 +: 64];
                @(negedge clk);
                check($sformatf("br_wr_data_w%0d", k), br_if.wr_data, words[k*64 +: 64]);
                check("br_cmd_en_in_write", br_if.cmd_en, 0);
                check("other_busy_in_write", m_busy[1-n], 1);
                @(posedge clk);
                #1;
            end
        end else begin
            @(negedge clk);
            check("br_cmd_en_single", br_if.cmd_en, 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (expq0.size() == 0 && expq1.size() == 0) break;
        end
        check("drain_remaining", 64'(expq0.size() + expq1.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_words();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin : main
        int s0, s1;
        int exp_g[$];
        int rem[2];
        int last, w;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = {$urandom, $urandom};
            ref_mem[i] = ram[i];
        end
        for (int n = 0; n < 2; n++) begin
            m_en[n] = 0; m_cmd[n] = 0; m_addr[n] = '0; m_wd[n] = '0; m_mask[n] = '0;
            beats[n] = 0;
        end
        rst = 1'b1;
        br_busy_drv = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m0_busy", m_busy[0], 1);
        check("rst_m1_busy", m_busy[1], 1);
        check("rst_br_cmd_en", br_if.cmd_en, 0);
        check("rst_m0_valid", m_valid[0], 0);
        check("rst_m1_valid", m_valid[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_last = 1;

        // both request while calibrating; first grant once br_busy drops
        grant_q.delete();
        fork
            issue(0, 1'b0, 10'h100, '0);
            issue(1, 1'b0, 10'h200, '0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("calib_m0_busy", m_busy[0], 1);
                    check("calib_m1_busy", m_busy[1], 1);
                    check("calib_br_cmd_en", br_if.cmd_en, 0);
                end
                @(posedge clk);
                #1;
                br_busy_drv = 1'b0;
            end
        join
        check("calib_first_grant", 64'(grant_q[0]), 64'(tie_pick(ref_last)));
        wait_drain();

        // m0 read alone
        s0 = beats[0];
        s1 = beats[1];
        issue(0, 1'b0, 10'h010, '0);
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            #1;
            if (beats[0] >= s0 + B) break;
        end
        @(negedge clk);
        check("m0_busy_after_last_beat", m_busy[0], 0);
        check("m0_beat_count", 64'(beats[0] - s0), B);
        check("m1_no_beats", 64'(beats[1] - s1), 0);
        @(posedge clk);
        #1;

        // m1 write then read back
        issue(1, 1'b1, 10'h020, {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111});
        issue(1, 1'b0, 10'h020, '0);
        wait_drain();

        // simultaneous back-to-back requests, two bursts per master
        ref_last = 1;
        grant_q.delete();
        fork
            begin issue(0, 1'b0, 10'h104, '0); issue(0, 1'b0, 10'h108, '0); end
            begin issue(1, 1'b0, 10'h204, '0); issue(1, 1'b0, 10'h208, '0); end
        join
        rem[0] = 2; rem[1] = 2; last = ref_last;
        exp_g.delete();
        while (rem[0] + rem[1] > 0) begin
            if (rem[0] > 0 && rem[1] > 0) w = tie_pick(last);
            else w = (rem[0] > 0) ? 0 : 1;
            exp_g.push_back(w);
            rem[w]--;
            last = w;
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("tie_grant_%0d", i), 64'(grant_q.size() > i ? grant_q[i] : -1), 64'(exp_g[i]));
        wait_drain();

        // reset during the 2nd beat of an m0 read
        s0 = beats[0];
        issue(0, 1'b0, 10'h040, '0);
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            #1;
            if (beats[0] >= s0 + 2) break;
        end
        rst = 1'b1;
        expq0.delete();
        expq1.delete();
        repeat (3) begin
            @(negedge clk);
            check("midrst_m0_busy", m_busy[0], 1);
            check("midrst_m1_busy", m_busy[1], 1);
            check("midrst_m0_valid", m_valid[0], 0);
            check("midrst_br_cmd_en", br_if.cmd_en, 0);
        end
        @(posedge clk);
        #1;
        br_busy_drv = 1'b1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        br_busy_drv = 1'b0;
        s1 = beats[1];
        issue(1, 1'b0, 10'h000, '0);
        wait_drain();
        check("post_rst_m1_beats", 64'(beats[1] - s1), B);

        // spurious valid while idle
        @(negedge clk);
        spurious = 1'b1;
        @(posedge clk);
        #2;
        @(negedge clk);
        check("spurious_m0_valid", m_valid[0], 0);
        check("spurious_m1_valid", m_valid[1], 0);
        @(posedge clk);
        #1;

        // randomized traffic, each master in its own address region
        fork
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue(0, 1'($urandom), 10'h100 + DW'(4 * $urandom_range(0, 15)), rand_words());
            end
            for (int i = 0; i < 12; i++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                issue(1, 1'($urandom), 10'h200 + DW'(4 * $urandom_range(0, 15)), rand_words());
            end
        join
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
